tmds_decoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 9 +
 rtl/tmds_symbol_decode.sv | 25 ++
 rtl/tmds_decoder.sv | 126 ++++++++++++
 tb/tb_tmds_decoder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: symbol width, control-token constants and alignment FSM states shared by the TMDS encoder and decoder
package tmds_pkg;
   localparam int SYM_W = 10;
   localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;
   typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_e;
endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational TMDS symbol decode
//   sym_i     10-bit aligned symbol
//   vd_o      decoded video byte (0 for control tokens)
//   cd_o      control code of a token (0 for data words)
//   vde_o     1 for a data word
//   is_ctrl_o 1 when sym_i is one of the four control tokens
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [SYM_W-1:0] sym_i,
   output logic [7:0]       vd_o,
   output logic [1:0]       cd_o,
   output logic             vde_o,
   output logic             is_ctrl_o
);
   logic [7:0] d;
   logic [6:0] x;
   // undo the optional inversion, then the XOR/XNOR chain selected by bit 8
   assign d         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
   assign x         = d[7:1] ^ d[6:0];
   assign is_ctrl_o = sym_i inside {CTRL_00, CTRL_01, CTRL_10, CTRL_11};
   assign cd_o      = sym_i == CTRL_01 ? 2'b01 : sym_i == CTRL_10 ? 2'b10 : sym_i == CTRL_11 ? 2'b11 : 2'b00;
   assign vde_o     = ~is_ctrl_o;
   assign vd_o      = is_ctrl_o ? 8'h00 : {sym_i[8] ? x : ~x, d[0]};
endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: per-channel TMDS receive decoder with word-alignment FSM
//   pixclk      pixel clock, rising edge
//   reset       synchronous active-high reset
//   TMDS        raw 10-bit symbol from the deserializer (bit 0 first on the wire)
//   VD/CD/VDE   decoded video data, control code and data-enable, 2-cycle latency
//   locked      word alignment achieved
//   bitslip     one-cycle request to shift the deserializer word boundary
//   slip_count  slips since the current lock attempt started, wraps 9->0
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int CTRL_RUN      = 8,
   parameter int SEARCH_WINDOW = 2048,
   parameter int SLIP_SETTLE   = 4,
   parameter int LOCK_TIMEOUT  = 4096
) (
   input  logic             pixclk,
   input  logic             reset,
   input  logic [SYM_W-1:0] TMDS,
   output logic [7:0]       VD,
   output logic [1:0]       CD,
   output logic             VDE,
   output logic             locked,
   output logic             bitslip,
   output logic [3:0]       slip_count
);
   localparam int RW = $clog2(CTRL_RUN) + 1;
   localparam int SW = $clog2(SEARCH_WINDOW) + 1;
   localparam int WW = $clog2(SLIP_SETTLE) + 1;
   localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
   logic [SYM_W-1:0] tmds_q;
   logic [7:0]       vd_q, dec_vd;
   logic [1:0]       cd_q, dec_cd, tok_q, tok_d;
   logic             vde_q, dec_vde, is_ctrl;
   state_e           state_q, state_d;
   logic [RW-1:0]    run_q, run_d;
   logic [SW-1:0]    srch_q, srch_d;
   logic [WW-1:0]    settle_q, settle_d;
   logic [TW-1:0]    to_q, to_d;
   logic             bitslip_q, bitslip_d;
   logic [3:0]       slip_q, slip_d;
   tmds_symbol_decode u_dec (
      .sym_i     (tmds_q),
      .vd_o      (dec_vd),
      .cd_o      (dec_cd),
      .vde_o     (dec_vde),
      .is_ctrl_o (is_ctrl)
   );
   assign VD         = vd_q;
   assign CD         = cd_q;
   assign VDE        = vde_q;
   assign locked     = state_q == LOCKED;
   assign bitslip    = bitslip_q;
   assign slip_count = slip_q;
   always_comb begin
      state_d   = state_q;
      run_d     = '0;
      tok_d     = tok_q;
      srch_d    = '0;
      settle_d  = '0;
      to_d      = '0;
      bitslip_d = 1'b0;
      slip_d    = slip_q;
      case (state_q)
         SEARCH: begin
            // a different token restarts the run at 1, a data word clears it
            run_d  = !is_ctrl ? '0 : (run_q != '0 && dec_cd == tok_q) ? run_q + 1'b1 : RW'(1);
            tok_d  = is_ctrl ? dec_cd : tok_q;
            srch_d = (is_ctrl || srch_q == SW'(SEARCH_WINDOW - 1)) ? '0 : srch_q + 1'b1;
            if (run_d == RW'(CTRL_RUN)) begin
               state_d = LOCKED;
               run_d   = '0;
            end else if (!is_ctrl && srch_q == SW'(SEARCH_WINDOW - 1)) begin
               state_d   = SLIP_WAIT;
               bitslip_d = 1'b1;
               slip_d    = slip_q == 4'd9 ? 4'd0 : slip_q + 1'b1;
            end
         end
         SLIP_WAIT: begin
            settle_d = settle_q + 1'b1;
            if (settle_q == WW'(SLIP_SETTLE - 1)) begin
               state_d  = SEARCH;
               settle_d = '0;
            end
         end
         LOCKED: begin
            to_d = is_ctrl ? '0 : to_q + 1'b1;
            if (!is_ctrl && to_q == TW'(LOCK_TIMEOUT - 1)) begin
               state_d = SEARCH;
               to_d    = '0;
               slip_d  = 4'd0;
            end
         end
         default: state_d = SEARCH;
      endcase
   end
   always_ff @(posedge pixclk) begin
      if (reset) begin
         tmds_q    <= '0;
         vd_q      <= '0;
         cd_q      <= '0;
         vde_q     <= 1'b0;
         state_q   <= SEARCH;
         run_q     <= '0;
         tok_q     <= '0;
         srch_q    <= '0;
         settle_q  <= '0;
         to_q      <= '0;
         bitslip_q <= 1'b0;
         slip_q    <= '0;
      end else begin
         tmds_q    <= TMDS;
         vd_q      <= dec_vd;
         cd_q      <= is_ctrl ? dec_cd : cd_q;
         vde_q     <= dec_vde;
         state_q   <= state_d;
         run_q     <= run_d;
         tok_q     <= tok_d;
         srch_q    <= srch_d;
         settle_q  <= settle_d;
         to_q      <= to_d;
         bitslip_q <= bitslip_d;
         slip_q    <= slip_d;
      end
   end
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed self-checking bench for tmds_decoder
module tb_tmds_decoder;
   import tmds_pkg::*;
   logic       pixclk = 1'b0;
   logic       reset  = 1'b1;
   logic [9:0] TMDS   = '0;
   logic [7:0] VD;
   logic [1:0] CD;
   logic       VDE, locked, bitslip;
   logic [3:0] slip_count;
   int         n_checks = 0;
   int         n_errors = 0;
   tmds_decoder #(
      .CTRL_RUN      (8),
      .SEARCH_WINDOW (16),
      .SLIP_SETTLE   (4),
      .LOCK_TIMEOUT  (64)
   ) dut (
      .pixclk     (pixclk),
      .reset      (reset),
      .TMDS       (TMDS),
      .VD         (VD),
      .CD         (CD),
      .VDE        (VDE),
      .locked     (locked),
      .bitslip    (bitslip),
      .slip_count (slip_count)
   );
   always #5 pixclk = ~pixclk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge pixclk);
      #1;
   endtask
   task automatic send(input logic [9:0] w);
      TMDS = w;
      cyc();
   endtask
   task automatic dec(input string tag, input logic [9:0] w, input logic [7:0] vd, input logic [1:0] cd, input logic vde);
      send(w);
      send(w);
      chk({tag, "_vd"}, VD, vd);
      chk({tag, "_cd"}, CD, cd);
      chk({tag, "_vde"}, VDE, vde);
   endtask
   function automatic logic [9:0] rot(input logic [9:0] t, input int k);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[i] = t[(i + k) % 10];
      return r;
   endfunction
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int off, prev, ns, pos;
      logic prev_bs;
      // reset with random input
      reset = 1'b1;
      repeat (3) send(10'($urandom));
      chk("rst_vd", VD, 0);
      chk("rst_cd", CD, 0);
      chk("rst_vde", VDE, 0);
      chk("rst_locked", locked, 0);
      chk("rst_bitslip", bitslip, 0);
      chk("rst_slipcnt", slip_count, 0);
      reset = 1'b0;
      // decode
      dec("tok00", CTRL_00, 8'h00, 2'b00, 1'b0);
      dec("tok11", CTRL_11, 8'h00, 2'b11, 1'b0);
      dec("ff", 10'h200, 8'hFF, 2'b11, 1'b1);
      dec("00", 10'h100, 8'h00, 2'b11, 1'b1);
      dec("a5", 10'h163, 8'hA5, 2'b11, 1'b1);
      dec("a5inv", 10'h39C, 8'hA5, 2'b11, 1'b1);
      send(CTRL_10);
      chk("lat1_vde", VDE, 1);
      send(CTRL_10);
      chk("lat2_vde", VDE, 0);
      chk("lat2_cd", CD, 2'b10);
      // lock: 7 tokens then data must not lock; token change restarts run
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (7) send(CTRL_01);
      repeat (4) begin
         send(10'h200);
         chk("run7_locked", locked, 0);
      end
      repeat (5) send(CTRL_10);
      for (int i = 1; i <= 8; i++) begin
         send(CTRL_01);
         chk($sformatf("run_tok%0d_locked", i), locked, 0);
      end
      cyc();
      chk("run8_locked", locked, 1);
      // misaligned stream, offset 3; each slip moves the boundary back one bit
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      off = 3;
      prev = 0;
      ns = 0;
      prev_bs = 1'b0;
      for (int i = 0; i < 300 && !locked; i++) begin
         send(rot(CTRL_00, off));
         if (bitslip) begin
            chk("bs_single", prev_bs, 0);
            if (ns > 0) chk("bs_spacing", i - prev, 20);
            prev = i;
            ns++;
            off = (off + 9) % 10;
         end
         prev_bs = bitslip;
      end
      chk("slip_locked", locked, 1);
      chk("slip_n", ns, 3);
      chk("slip_count3", slip_count, 3);
      // lock timeout with data only
      for (int n = 1; n <= 65; n++) begin
         send(10'h200);
         chk("to_bitslip", bitslip, 0);
         if (n == 64) chk("to_locked64", locked, 1);
      end
      chk("to_locked65", locked, 0);
      chk("to_slipcnt", slip_count, 0);
      // reset while in SLIP_WAIT
      pos = 0;
      for (int i = 1; i <= 40 && pos == 0; i++) begin
         send(10'h200);
         if (bitslip) pos = i;
      end
      chk("sw_pulse_seen", pos, 16);
      reset = 1'b1;
      send(10'h200);
      chk("sw_rst_bitslip", bitslip, 0);
      chk("sw_rst_locked", locked, 0);
      chk("sw_rst_slipcnt", slip_count, 0);
      reset = 1'b0;
      // fresh search: first slip 16 cycles after release, then count wraps 9->0
      for (int k = 1; k <= 10; k++) begin
         pos = 0;
         for (int i = 1; i <= 40 && pos == 0; i++) begin
            send(10'h200);
            if (bitslip) pos = i;
         end
         chk($sformatf("wrap_gap%0d", k), pos, k == 1 ? 16 : 20);
         chk($sformatf("wrap_cnt%0d", k), slip_count, k % 10);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
